// File: rtl/ufm_responder.sv
// ufm_responder: serial UFM responder with address/data shift registers, timed erase/program and oscillator.
module ufm_responder #(
  parameter int ADDR_W       = 9,
  parameter int ERASE_CYCLES = 64,
  parameter int PROG_CYCLES  = 16,
  parameter int RTP_CYCLES   = 32,
  parameter int OSC_DIV      = 4
) (
  input  logic C14M,
  input  logic Reset,
  input  logic ARCLK,
  input  logic ARDIn,
  input  logic ARShift,
  input  logic DRCLK,
  input  logic DRDIn,
  input  logic DRShift,
  input  logic Erase,
  input  logic Program,
  input  logic OscEna,
  output logic DRDOut,
  output logic Busy,
  output logic RTPBusy,
  output logic Osc
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXC = ERASE_CYCLES > PROG_CYCLES ?
                        (ERASE_CYCLES > RTP_CYCLES ? ERASE_CYCLES : RTP_CYCLES) :
                        (PROG_CYCLES > RTP_CYCLES ? PROG_CYCLES : RTP_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int DW = $clog2(OSC_DIV) + 1;
  typedef enum logic [1:0] {RTP, IDLE, ERASE, PROG} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] ar, paddr;
  logic [15:0] dr, pdata;
  logic ar_q, dr_q, er_q, pg_q, sec, busy, rtp_busy, osc;
  logic [DW-1:0] div;
  logic ar_rise, dr_rise, er_rise, pg_rise, idle, done;
  // Array survives Reset; the declaration value models erased flash at power-up.
  logic [15:0] mem [DEPTH] = '{default: 16'hFFFF};
  assign ar_rise = ARCLK & ~ar_q;
  assign dr_rise = DRCLK & ~dr_q;
  assign er_rise = Erase & ~er_q;
  assign pg_rise = Program & ~pg_q;
  assign idle = state == IDLE;
  assign done = (state == RTP   && cnt == CW'(RTP_CYCLES - 1)) ||
                (state == ERASE && cnt == CW'(ERASE_CYCLES - 1)) ||
                (state == PROG  && cnt == CW'(PROG_CYCLES - 1));
  always_comb begin
    nxt = state;
    if (idle) nxt = er_rise ? ERASE : pg_rise ? PROG : IDLE;
    else if (done) nxt = IDLE;
  end
  always_ff @(posedge C14M) begin
    if (Reset) begin
      state    <= RTP;
      cnt      <= '0;
      ar       <= '0;
      dr       <= '0;
      paddr    <= '0;
      pdata    <= '0;
      sec      <= 1'b0;
      {ar_q, dr_q, er_q, pg_q} <= '0;
      busy     <= 1'b0;
      rtp_busy <= 1'b1;
      osc      <= 1'b0;
      div      <= '0;
    end else begin
      {ar_q, dr_q, er_q, pg_q} <= {ARCLK, DRCLK, Erase, Program};
      state    <= nxt;
      cnt      <= idle ? '0 : cnt + 1'b1;
      busy     <= nxt == ERASE || nxt == PROG;
      rtp_busy <= nxt == RTP;
      if (idle && er_rise) sec <= ar[ADDR_W-1];
      if (idle && pg_rise) begin
        paddr <= ar;
        pdata <= dr;
      end
      if (idle && ar_rise) ar <= ARShift ? {ar[ADDR_W-2:0], ARDIn} : ar + 1'b1;
      if (idle && dr_rise) dr <= DRShift ? {dr[14:0], DRDIn} : mem[ar];
      if (!OscEna) begin
        osc <= 1'b0;
        div <= '0;
      end else if (div == DW'(OSC_DIV / 2 - 1)) begin
        osc <= ~osc;
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end
  // Commit only on the completion cycle, so a Reset mid-operation leaves the array untouched.
  always_ff @(posedge C14M) begin
    if (!Reset && done && state == ERASE) begin
      for (int j = 0; j < DEPTH / 2; j++) mem[{sec, (ADDR_W - 1)'(j)}] <= 16'hFFFF;
    end else if (!Reset && done && state == PROG) begin
      mem[paddr] <= mem[paddr] & pdata;
    end
  end
  assign DRDOut  = dr[15];
  assign Busy    = busy;
  assign RTPBusy = rtp_busy;
  assign Osc     = osc;
endmodule

// File: tb/tb_ufm_responder.sv
// tb_ufm_responder: directed scoreboard bench for ufm_responder using a behavioural array model.
module tb_ufm_responder;
  logic clk = 1'b0;
  logic Reset, ARCLK, ARDIn, ARShift, DRCLK, DRDIn, DRShift, Erase, Program, OscEna;
  logic DRDOut, Busy, RTPBusy, Osc;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q [$];
  logic [15:0] mdl [512];
  logic [8:0] m_ar;
  logic [15:0] m_dr;

  ufm_responder dut (
    .C14M(clk), .Reset(Reset), .ARCLK(ARCLK), .ARDIn(ARDIn), .ARShift(ARShift),
    .DRCLK(DRCLK), .DRDIn(DRDIn), .DRShift(DRShift), .Erase(Erase), .Program(Program),
    .OscEna(OscEna), .DRDOut(DRDOut), .Busy(Busy), .RTPBusy(RTPBusy), .Osc(Osc)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic ar_clk(input logic sh, input logic din);
    ARShift = sh; ARDIn = din; ARCLK = 1'b1;
    @(negedge clk);
    ARCLK = 1'b0;
    @(negedge clk);
    m_ar = sh ? {m_ar[7:0], din} : m_ar + 9'd1;
  endtask

  task automatic dr_clk(input logic sh, input logic din);
    DRShift = sh; DRDIn = din; DRCLK = 1'b1;
    @(negedge clk);
    DRCLK = 1'b0;
    @(negedge clk);
    m_dr = sh ? {m_dr[14:0], din} : mdl[m_ar];
  endtask

  task automatic set_ar(input logic [8:0] a);
    for (int i = 8; i >= 0; i--) ar_clk(1'b1, a[i]);
  endtask

  task automatic set_dr(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) dr_clk(1'b1, d[i]);
  endtask

  task automatic shift_out(input string tag);
    logic [15:0] obs;
    push({16'h0, m_dr});
    for (int i = 15; i >= 0; i--) begin
      obs[i] = DRDOut;
      if (i > 0) dr_clk(1'b1, 1'b0);
    end
    sb_check(tag, {16'h0, obs});
  endtask

  task automatic read_word(input logic [8:0] a, input string tag);
    set_ar(a);
    dr_clk(1'b0, 1'b0);
    shift_out(tag);
  endtask

  task automatic start_op(input logic er, input logic pg);
    Erase = er; Program = pg;
    @(negedge clk);
    Erase = 1'b0; Program = 1'b0;
  endtask

  task automatic wait_idle(output int len);
    len = 0;
    for (int i = 0; i < 300 && Busy; i++) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic model_erase(input logic s);
    for (int i = 0; i < 512; i++) if (i[8] == s) mdl[i] = 16'hFFFF;
  endtask

  task automatic program_word(input logic [8:0] a, input logic [15:0] d, input string tag);
    int len;
    set_ar(a);
    set_dr(d);
    push(32'd16);
    mdl[m_ar] = mdl[m_ar] & m_dr;
    start_op(1'b0, 1'b1);
    wait_idle(len);
    sb_check(tag, len);
  endtask

  initial begin
    int len, rtp_n, busy_n, dro_n;
    logic [7:0] osc_pat;
    for (int i = 0; i < 512; i++) mdl[i] = 16'hFFFF;
    m_ar = '0; m_dr = '0;
    {ARCLK, ARDIn, ARShift, DRCLK, DRDIn, DRShift, Erase, Program, OscEna} = '0;
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    push(32'd1); sb_check("reset_rtpbusy", RTPBusy);
    push(32'd0); sb_check("reset_busy", Busy);
    push(32'd0); sb_check("reset_drdout", DRDOut);
    push(32'd0); sb_check("reset_osc", Osc);
    Reset = 1'b0;
    rtp_n = 0; busy_n = 0; dro_n = 0;
    for (int i = 0; i < 40; i++) begin
      rtp_n += int'(RTPBusy);
      busy_n += int'(Busy);
      dro_n += int'(DRDOut);
      @(negedge clk);
    end
    push(32'd32); sb_check("rtp_window_len", rtp_n);
    push(32'd0); sb_check("busy_during_rtp", busy_n);
    push(32'd0); sb_check("drdout_during_rtp", dro_n);
    OscEna = 1'b1;
    push(32'h66);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      osc_pat[i] = Osc;
    end
    sb_check("osc_pattern", osc_pat);
    OscEna = 1'b0;
    @(negedge clk);
    push(32'd0); sb_check("osc_disabled", Osc);
    set_ar(9'h1FF);
    dr_clk(1'b0, 1'b0);
    push(32'd1); sb_check("drdout_after_load", DRDOut);
    shift_out("load_1ff_blank");
    program_word(9'h1FF, 16'h1234, "prog_1ff_len");
    ar_clk(1'b0, 1'b0);
    dr_clk(1'b0, 1'b0);
    shift_out("ar_wrap_to_0");
    read_word(9'h1FF, "read_1ff");
    program_word(9'h005, 16'h7F3C, "prog_005_len");
    read_word(9'h005, "read_005_first");
    program_word(9'h005, 16'hFF00, "prog_005_and_len");
    read_word(9'h005, "read_005_and");
    program_word(9'h020, 16'hA5A5, "prog_020_len");
    program_word(9'h120, 16'h5A5A, "prog_120_len");
    set_ar(9'h020);
    push(32'd64);
    model_erase(m_ar[8]);
    start_op(1'b1, 1'b0);
    wait_idle(len);
    sb_check("erase_s0_len", len);
    read_word(9'h005, "erased_005");
    read_word(9'h020, "erased_020");
    read_word(9'h120, "kept_120");
    read_word(9'h1FF, "kept_1ff");
    set_ar(9'h030);
    set_dr(16'h0F0F);
    mdl[m_ar] = mdl[m_ar] & m_dr;
    start_op(1'b0, 1'b1);
    ARShift = 1'b1; ARDIn = 1'b1; DRShift = 1'b1; DRDIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ARCLK = 1'b1; DRCLK = 1'b1; Program = 1'b1;
      @(negedge clk);
      ARCLK = 1'b0; DRCLK = 1'b0; Program = 1'b0;
      @(negedge clk);
    end
    push(32'd1); sb_check("busy_during_disturb", Busy);
    wait_idle(len);
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      busy_n += int'(Busy);
      @(negedge clk);
    end
    push(32'd0); sb_check("no_second_busy", busy_n);
    shift_out("dr_held_while_busy");
    dr_clk(1'b0, 1'b0);
    shift_out("ar_held_while_busy");
    set_ar(9'h120);
    set_dr(16'h0000);
    push(32'd64);
    model_erase(m_ar[8]);
    start_op(1'b1, 1'b1);
    wait_idle(len);
    sb_check("erase_wins_len", len);
    read_word(9'h120, "erase_wins_120");
    read_word(9'h1FF, "erase_wins_1ff");
    set_ar(9'h010);
    set_dr(16'h0000);
    start_op(1'b0, 1'b1);
    repeat (9) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    m_ar = '0; m_dr = '0;
    push(32'd0); sb_check("abort_busy", Busy);
    push(32'd1); sb_check("abort_rtpbusy", RTPBusy);
    for (int i = 0; i < 100 && RTPBusy; i++) @(negedge clk);
    push(32'd0); sb_check("rtp_done_after_abort", RTPBusy);
    read_word(9'h010, "abort_no_write");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
